// File: rtl/mig_seq_evaluator_if.sv
// Handshake and program-load bundle for the sequential MIG evaluator.
// The master drives programs and requests; the slave (evaluator) answers.
interface mig_seq_evaluator_if #(
  parameter int unsigned NUM_INPUTS = 7,
  parameter int unsigned MAX_NODES  = 16
);
  localparam int unsigned SRC_W = $clog2(1 + NUM_INPUTS + MAX_NODES);
  localparam int unsigned OP_W  = SRC_W + 1;
  localparam int unsigned IW    = 3 * OP_W;
  localparam int unsigned AW    = $clog2(MAX_NODES);

  logic                  prog_we;
  logic [AW-1:0]         prog_addr;
  logic [IW-1:0]         prog_data;
  logic                  prog_drop;
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_INPUTS-1:0] in_x;
  logic [AW:0]           in_nodes;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_value;
  logic                  out_err;
  logic                  busy;

  modport master (
    output prog_we, prog_addr, prog_data, in_valid, in_x, in_nodes, out_ready,
    input  prog_drop, in_ready, out_valid, out_value, out_err, busy
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, in_valid, in_x, in_nodes, out_ready,
    output prog_drop, in_ready, out_valid, out_value, out_err, busy
  );
endinterface

// File: rtl/mig_seq_evaluator.sv
// Sequential MIG evaluator: one MAJ3 unit stepped through a programmable node list,
// one node per cycle, result of node N-1 returned over a valid/ready pair.
module mig_seq_evaluator #(
  parameter int unsigned NUM_INPUTS = 7,
  parameter int unsigned MAX_NODES  = 16
) (
  input logic              clk,
  input logic              rst_n,
  mig_seq_evaluator_if.slave bus
);
  localparam int unsigned SRC_W     = $clog2(1 + NUM_INPUTS + MAX_NODES);
  localparam int unsigned OP_W      = SRC_W + 1;
  localparam int unsigned IW        = 3 * OP_W;
  localparam int unsigned AW        = $clog2(MAX_NODES);
  localparam int unsigned NUM_SRC   = 2 ** SRC_W;
  localparam int unsigned NODE_BASE = NUM_INPUTS + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StEval = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         ctr_q, ctr_d;
  logic [AW:0]           n_q, n_d;
  logic [NUM_INPUTS-1:0] x_q, x_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_value_q, out_value_d;
  logic                  out_err_q, out_err_d;
  logic                  prog_drop_q, prog_drop_d;
  logic [IW-1:0]         mem_q [MAX_NODES];
  logic [IW-1:0]         mem_d [MAX_NODES];
  logic                  node_q [MAX_NODES];
  logic                  node_d [MAX_NODES];

  // Flat view of every source code: its value and whether node ctr_q may read it.
  // Unused codes and self/forward node refs stay 0 in src_ok.
  logic [NUM_SRC-1:0] src_val, src_ok;

  always_comb begin
    src_val    = '0;
    src_ok     = '0;
    src_ok[0]  = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      src_val[1 + i] = x_q[i];
      src_ok[1 + i]  = 1'b1;
    end
    for (int j = 0; j < MAX_NODES; j++) begin
      src_val[NODE_BASE + j] = node_q[j];
      src_ok[NODE_BASE + j]  = (AW'(j) < ctr_q);
    end
  end

  logic [IW-1:0]    word;
  logic [OP_W-1:0]  op   [3];
  logic [2:0]       opv;
  logic [2:0]       opbad;
  logic             maj;

  always_comb begin
    word = mem_q[ctr_q];
    for (int k = 0; k < 3; k++) begin
      op[k]    = word[IW-1-k*OP_W -: OP_W];
      opbad[k] = ~src_ok[op[k][SRC_W-1:0]];
      opv[k]   = (src_val[op[k][SRC_W-1:0]] & src_ok[op[k][SRC_W-1:0]]) ^ op[k][OP_W-1];
    end
    maj = (opv[0] & opv[1]) | (opv[0] & opv[2]) | (opv[1] & opv[2]);
  end

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    n_d         = n_q;
    x_d         = x_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    prog_drop_d = 1'b0;
    mem_d       = mem_q;
    node_d      = node_q;

    if (bus.prog_we) begin
      if (state_q == StIdle) mem_d[bus.prog_addr] = bus.prog_data;
      else                   prog_drop_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          x_d   = bus.in_x;
          n_d   = bus.in_nodes;
          ctr_d = '0;
          err_d = 1'b0;
          if (bus.in_nodes == '0 || bus.in_nodes > (AW + 1)'(MAX_NODES)) begin
            state_d     = StDone;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
            out_value_d = 1'b0;
            out_err_d   = 1'b1;
          end else begin
            state_d = StEval;
          end
        end
      end
      StEval: begin
        node_d[ctr_q] = maj;
        err_d         = err_q | (|opbad);
        ctr_d         = ctr_q + AW'(1);
        if ({1'b0, ctr_q} == n_q - (AW + 1)'(1)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          out_value_d = maj;
          out_err_d   = err_q | (|opbad);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ctr_q       <= '0;
      n_q         <= '0;
      x_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= 1'b0;
      out_err_q   <= 1'b0;
      prog_drop_q <= 1'b0;
      mem_q       <= '{default: '0};
      node_q      <= '{default: 1'b0};
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      n_q         <= n_d;
      x_q         <= x_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
      prog_drop_q <= prog_drop_d;
      mem_q       <= mem_d;
      node_q      <= node_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_err   = out_err_q;
  assign bus.prog_drop = prog_drop_q;
endmodule

// File: tb/tb_mig_seq_evaluator.sv
// Randomized self-checking bench for mig_seq_evaluator against a behavioural
// majority-graph model held in the bench.
module tb_mig_seq_evaluator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mig_seq_evaluator_if bus ();

  mig_seq_evaluator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] prog_m [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] mk(input int a, input int b, input int c);
    return {1'b0, 5'(a), 1'b0, 5'(b), 1'b0, 5'(c)};
  endfunction

  // Node i reads const0, x(src-1), or an earlier node result; anything else is an error.
  function automatic void model(input logic [6:0] x, input int n, output logic v,
                                output logic e);
    logic res [16];
    logic o [3];
    logic [5:0] op;
    logic [17:0] w;
    int src;
    int cnt;
    v = 1'b0;
    e = 1'b0;
    for (int i = 0; i < 16; i++) res[i] = 1'b0;
    if (n < 1 || n > 16) begin
      e = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = prog_m[i];
      for (int k = 0; k < 3; k++) begin
        op  = w[17-6*k -: 6];
        src = int'(op[4:0]);
        if (src == 0) o[k] = 1'b0;
        else if (src <= 7) o[k] = x[src-1];
        else if (src <= 23 && (src - 8) < i) o[k] = res[src-8];
        else begin
          o[k] = 1'b0;
          e    = 1'b1;
        end
        o[k] = o[k] ^ op[5];
      end
      cnt    = o[0] + o[1] + o[2];
      res[i] = (cnt >= 2);
    end
    v = res[n-1];
  endfunction

  task automatic write_node(input int addr, input logic [17:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'(addr);
    bus.prog_data = data;
    @(posedge clk);
    #1;
    bus.prog_we = 1'b0;
    prog_m[addr] = data;
  endtask

  task automatic send(input logic [6:0] x, input int n);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_nodes = 5'(n);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq("pop_valid_clr", 32'(bus.out_valid), 32'd0);
    check_eq("pop_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_exp(input string tag, input logic [6:0] x, input int n,
                         input logic ev, input logic ee);
    int lat;
    send(x, n);
    wait_done(lat);
    check_eq({tag, "_value"}, 32'(bus.out_value), 32'(ev));
    check_eq({tag, "_err"}, 32'(bus.out_err), 32'(ee));
    check_eq({tag, "_lat"}, 32'(lat), (n >= 1 && n <= 16) ? 32'(n) : 32'd0);
    pop();
  endtask

  task automatic run_check(input string tag, input logic [6:0] x, input int n);
    logic ev, ee;
    model(x, n, ev, ee);
    run_exp(tag, x, n, ev, ee);
  endtask

  task automatic load_t1();
    write_node(0, mk(1, 2, 7));
    write_node(1, mk(2, 6, 8));
    write_node(2, mk(1, 3, 8));
    write_node(3, mk(5, 9, 10));
    write_node(4, mk(3, 10, 11));
    write_node(5, mk(1, 6, 12));
    write_node(6, mk(4, 11, 13));
  endtask

  initial begin
    logic ev, ee, hv;
    int lat, seen, src;
    logic [5:0] ops [3];

    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_nodes = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) prog_m[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_value", 32'(bus.out_value), 32'd0);
    check_eq("rst_out_err", 32'(bus.out_err), 32'd0);
    check_eq("rst_prog_drop", 32'(bus.prog_drop), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);

    // T1: fixed program, all-ones input
    load_t1();
    run_exp("t1", 7'h7F, 7, 1'b1, 1'b0);

    // T2: exhaustive sweep of the same program
    run_exp("t2_zero", 7'h00, 7, 1'b0, 1'b0);
    for (int x = 0; x < 128; x++) run_check("t2", 7'(x), 7);

    // T3: inverted constants force the majority high
    write_node(0, {6'h20, 6'h20, 6'h01});
    run_exp("t3_x0", 7'h00, 1, 1'b1, 1'b0);
    run_exp("t3_x1", 7'h01, 1, 1'b1, 1'b0);

    // T4: forward reference and illegal counts
    write_node(0, mk(9, 1, 2));
    write_node(1, mk(8, 3, 4));
    run_check("t4_fwd", 7'h03, 2);
    check_eq("t4_fwd_err_const", 32'(bus.out_err), 32'd1);
    run_exp("t4_n0", 7'h7F, 0, 1'b0, 1'b1);
    run_exp("t4_n17", 7'h7F, 17, 1'b0, 1'b1);
    write_node(2, mk(30, 1, 1));
    run_check("t4_unused_code", 7'h01, 3);

    // T5: dropped write during EVAL, then hold in DONE
    load_t1();
    send(7'h5A, 7);
    bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = {6'h20, 6'h20, 6'h01};
    @(posedge clk);
    #1;
    bus.prog_we = 1'b0;
    check_eq("t5_drop_pulse", 32'(bus.prog_drop), 32'd1);
    @(posedge clk);
    #1;
    check_eq("t5_drop_end", 32'(bus.prog_drop), 32'd0);
    wait_done(lat);
    check_eq("t5_lat", 32'(lat + 2), 32'd7);
    model(7'h5A, 7, ev, ee);
    hv = bus.out_value;
    check_eq("t5_value", 32'(hv), 32'(ev));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_eq("t5_hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("t5_hold_value", 32'(bus.out_value), 32'(hv));
      check_eq("t5_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    pop();
    run_check("t5_mem_kept", 7'h5A, 7);

    // Randomized programs, inputs and counts
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 16; i++) begin
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(0, 9) == 0) src = int'($urandom_range(0, 31));
          else src = int'($urandom_range(0, 7 + i));
          ops[k] = {1'($urandom_range(0, 1)), 5'(src)};
        end
        write_node(i, {ops[0], ops[1], ops[2]});
      end
      for (int r = 0; r < 6; r++) begin
        if ($urandom_range(0, 5) == 0) run_check("rnd", 7'($urandom), int'($urandom_range(0, 17)));
        else run_check("rnd", 7'($urandom), int'($urandom_range(1, 16)));
      end
    end

    // Write and request in the same IDLE cycle: EVAL sees the new word
    write_node(0, mk(0, 0, 0));
    bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = {6'h20, 6'h20, 6'h01};
    prog_m[0] = {6'h20, 6'h20, 6'h01};
    send(7'h11, 1);
    bus.prog_we = 1'b0;
    wait_done(lat);
    check_eq("same_cycle_value", 32'(bus.out_value), 32'd1);
    check_eq("same_cycle_lat", 32'(lat), 32'd1);
    pop();

    // T6: reset in the middle of EVAL
    load_t1();
    send(7'h7F, 7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq("t6_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) prog_m[i] = '0;
    check_eq("t6_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t6_out_value", 32'(bus.out_value), 32'd0);
    check_eq("t6_out_err", 32'(bus.out_err), 32'd0);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1;
    end
    check_eq("t6_no_valid", 32'(seen), 32'd0);
    run_exp("t6_cleared7", 7'h7F, 7, 1'b0, 1'b0);
    run_exp("t6_cleared1", 7'h7F, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
